add_round_key: RTL and testbench

ADD_ROUND_KEY -- requirements
Module: add_round_key

---
 rtl/add_round_key_pkg.sv | 32 +++
 rtl/aes_sbox.sv | 46 ++++
 rtl/add_round_key.sv | 47 ++++
 tb/tb_add_round_key.sv | 107 ++++++++++
 4 files changed

// File: rtl/add_round_key_pkg.sv
// Shared widths, round limits and the round-constant table for AES-128 key expansion.
package add_round_key_pkg;

  localparam int unsigned KEY_W     = 128;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MAX_ROUND = 10;

  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } key_words_t;

  // Rcon byte for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a purely combinational 256-entry lookup.
module aes_sbox (
  input  logic [7:0] val,
  output logic [7:0] sub_c
);

  always_comb begin
    sub_c = 8'h00;
    case (val)
      8'h00: sub_c = 8'h63; 8'h01: sub_c = 8'h7c; 8'h02: sub_c = 8'h77; 8'h03: sub_c = 8'h7b; 8'h04: sub_c = 8'hf2; 8'h05: sub_c = 8'h6b; 8'h06: sub_c = 8'h6f; 8'h07: sub_c = 8'hc5;
      8'h08: sub_c = 8'h30; 8'h09: sub_c = 8'h01; 8'h0a: sub_c = 8'h67; 8'h0b: sub_c = 8'h2b; 8'h0c: sub_c = 8'hfe; 8'h0d: sub_c = 8'hd7; 8'h0e: sub_c = 8'hab; 8'h0f: sub_c = 8'h76;
      8'h10: sub_c = 8'hca; 8'h11: sub_c = 8'h82; 8'h12: sub_c = 8'hc9; 8'h13: sub_c = 8'h7d; 8'h14: sub_c = 8'hfa; 8'h15: sub_c = 8'h59; 8'h16: sub_c = 8'h47; 8'h17: sub_c = 8'hf0;
      8'h18: sub_c = 8'had; 8'h19: sub_c = 8'hd4; 8'h1a: sub_c = 8'ha2; 8'h1b: sub_c = 8'haf; 8'h1c: sub_c = 8'h9c; 8'h1d: sub_c = 8'ha4; 8'h1e: sub_c = 8'h72; 8'h1f: sub_c = 8'hc0;
      8'h20: sub_c = 8'hb7; 8'h21: sub_c = 8'hfd; 8'h22: sub_c = 8'h93; 8'h23: sub_c = 8'h26; 8'h24: sub_c = 8'h36; 8'h25: sub_c = 8'h3f; 8'h26: sub_c = 8'hf7; 8'h27: sub_c = 8'hcc;
      8'h28: sub_c = 8'h34; 8'h29: sub_c = 8'ha5; 8'h2a: sub_c = 8'he5; 8'h2b: sub_c = 8'hf1; 8'h2c: sub_c = 8'h71; 8'h2d: sub_c = 8'hd8; 8'h2e: sub_c = 8'h31; 8'h2f: sub_c = 8'h15;
      8'h30: sub_c = 8'h04; 8'h31: sub_c = 8'hc7; 8'h32: sub_c = 8'h23; 8'h33: sub_c = 8'hc3; 8'h34: sub_c = 8'h18; 8'h35: sub_c = 8'h96; 8'h36: sub_c = 8'h05; 8'h37: sub_c = 8'h9a;
      8'h38: sub_c = 8'h07; 8'h39: sub_c = 8'h12; 8'h3a: sub_c = 8'h80; 8'h3b: sub_c = 8'he2; 8'h3c: sub_c = 8'heb; 8'h3d: sub_c = 8'h27; 8'h3e: sub_c = 8'hb2; 8'h3f: sub_c = 8'h75;
      8'h40: sub_c = 8'h09; 8'h41: sub_c = 8'h83; 8'h42: sub_c = 8'h2c; 8'h43: sub_c = 8'h1a; 8'h44: sub_c = 8'h1b; 8'h45: sub_c = 8'h6e; 8'h46: sub_c = 8'h5a; 8'h47: sub_c = 8'ha0;
      8'h48: sub_c = 8'h52; 8'h49: sub_c = 8'h3b; 8'h4a: sub_c = 8'hd6; 8'h4b: sub_c = 8'hb3; 8'h4c: sub_c = 8'h29; 8'h4d: sub_c = 8'he3; 8'h4e: sub_c = 8'h2f; 8'h4f: sub_c = 8'h84;
      8'h50: sub_c = 8'h53; 8'h51: sub_c = 8'hd1; 8'h52: sub_c = 8'h00; 8'h53: sub_c = 8'hed; 8'h54: sub_c = 8'h20; 8'h55: sub_c = 8'hfc; 8'h56: sub_c = 8'hb1; 8'h57: sub_c = 8'h5b;
      8'h58: sub_c = 8'h6a; 8'h59: sub_c = 8'hcb; 8'h5a: sub_c = 8'hbe; 8'h5b: sub_c = 8'h39; 8'h5c: sub_c = 8'h4a; 8'h5d: sub_c = 8'h4c; 8'h5e: sub_c = 8'h58; 8'h5f: sub_c = 8'hcf;
      8'h60: sub_c = 8'hd0; 8'h61: sub_c = 8'hef; 8'h62: sub_c = 8'haa; 8'h63: sub_c = 8'hfb; 8'h64: sub_c = 8'h43; 8'h65: sub_c = 8'h4d; 8'h66: sub_c = 8'h33; 8'h67: sub_c = 8'h85;
      8'h68: sub_c = 8'h45; 8'h69: sub_c = 8'hf9; 8'h6a: sub_c = 8'h02; 8'h6b: sub_c = 8'h7f; 8'h6c: sub_c = 8'h50; 8'h6d: sub_c = 8'h3c; 8'h6e: sub_c = 8'h9f; 8'h6f: sub_c = 8'ha8;
      8'h70: sub_c = 8'h51; 8'h71: sub_c = 8'ha3; 8'h72: sub_c = 8'h40; 8'h73: sub_c = 8'h8f; 8'h74: sub_c = 8'h92; 8'h75: sub_c = 8'h9d; 8'h76: sub_c = 8'h38; 8'h77: sub_c = 8'hf5;
      8'h78: sub_c = 8'hbc; 8'h79: sub_c = 8'hb6; 8'h7a: sub_c = 8'hda; 8'h7b: sub_c = 8'h21; 8'h7c: sub_c = 8'h10; 8'h7d: sub_c = 8'hff; 8'h7e: sub_c = 8'hf3; 8'h7f: sub_c = 8'hd2;
      8'h80: sub_c = 8'hcd; 8'h81: sub_c = 8'h0c; 8'h82: sub_c = 8'h13; 8'h83: sub_c = 8'hec; 8'h84: sub_c = 8'h5f; 8'h85: sub_c = 8'h97; 8'h86: sub_c = 8'h44; 8'h87: sub_c = 8'h17;
      8'h88: sub_c = 8'hc4; 8'h89: sub_c = 8'ha7; 8'h8a: sub_c = 8'h7e; 8'h8b: sub_c = 8'h3d; 8'h8c: sub_c = 8'h64; 8'h8d: sub_c = 8'h5d; 8'h8e: sub_c = 8'h19; 8'h8f: sub_c = 8'h73;
      8'h90: sub_c = 8'h60; 8'h91: sub_c = 8'h81; 8'h92: sub_c = 8'h4f; 8'h93: sub_c = 8'hdc; 8'h94: sub_c = 8'h22; 8'h95: sub_c = 8'h2a; 8'h96: sub_c = 8'h90; 8'h97: sub_c = 8'h88;
      8'h98: sub_c = 8'h46; 8'h99: sub_c = 8'hee; 8'h9a: sub_c = 8'hb8; 8'h9b: sub_c = 8'h14; 8'h9c: sub_c = 8'hde; 8'h9d: sub_c = 8'h5e; 8'h9e: sub_c = 8'h0b; 8'h9f: sub_c = 8'hdb;
      8'ha0: sub_c = 8'he0; 8'ha1: sub_c = 8'h32; 8'ha2: sub_c = 8'h3a; 8'ha3: sub_c = 8'h0a; 8'ha4: sub_c = 8'h49; 8'ha5: sub_c = 8'h06; 8'ha6: sub_c = 8'h24; 8'ha7: sub_c = 8'h5c;
      8'ha8: sub_c = 8'hc2; 8'ha9: sub_c = 8'hd3; 8'haa: sub_c = 8'hac; 8'hab: sub_c = 8'h62; 8'hac: sub_c = 8'h91; 8'had: sub_c = 8'h95; 8'hae: sub_c = 8'he4; 8'haf: sub_c = 8'h79;
      8'hb0: sub_c = 8'he7; 8'hb1: sub_c = 8'hc8; 8'hb2: sub_c = 8'h37; 8'hb3: sub_c = 8'h6d; 8'hb4: sub_c = 8'h8d; 8'hb5: sub_c = 8'hd5; 8'hb6: sub_c = 8'h4e; 8'hb7: sub_c = 8'ha9;
      8'hb8: sub_c = 8'h6c; 8'hb9: sub_c = 8'h56; 8'hba: sub_c = 8'hf4; 8'hbb: sub_c = 8'hea; 8'hbc: sub_c = 8'h65; 8'hbd: sub_c = 8'h7a; 8'hbe: sub_c = 8'hae; 8'hbf: sub_c = 8'h08;
      8'hc0: sub_c = 8'hba; 8'hc1: sub_c = 8'h78; 8'hc2: sub_c = 8'h25; 8'hc3: sub_c = 8'h2e; 8'hc4: sub_c = 8'h1c; 8'hc5: sub_c = 8'ha6; 8'hc6: sub_c = 8'hb4; 8'hc7: sub_c = 8'hc6;
      8'hc8: sub_c = 8'he8; 8'hc9: sub_c = 8'hdd; 8'hca: sub_c = 8'h74; 8'hcb: sub_c = 8'h1f; 8'hcc: sub_c = 8'h4b; 8'hcd: sub_c = 8'hbd; 8'hce: sub_c = 8'h8b; 8'hcf: sub_c = 8'h8a;
      8'hd0: sub_c = 8'h70; 8'hd1: sub_c = 8'h3e; 8'hd2: sub_c = 8'hb5; 8'hd3: sub_c = 8'h66; 8'hd4: sub_c = 8'h48; 8'hd5: sub_c = 8'h03; 8'hd6: sub_c = 8'hf6; 8'hd7: sub_c = 8'h0e;
      8'hd8: sub_c = 8'h61; 8'hd9: sub_c = 8'h35; 8'hda: sub_c = 8'h57; 8'hdb: sub_c = 8'hb9; 8'hdc: sub_c = 8'h86; 8'hdd: sub_c = 8'hc1; 8'hde: sub_c = 8'h1d; 8'hdf: sub_c = 8'h9e;
      8'he0: sub_c = 8'he1; 8'he1: sub_c = 8'hf8; 8'he2: sub_c = 8'h98; 8'he3: sub_c = 8'h11; 8'he4: sub_c = 8'h69; 8'he5: sub_c = 8'hd9; 8'he6: sub_c = 8'h8e; 8'he7: sub_c = 8'h94;
      8'he8: sub_c = 8'h9b; 8'he9: sub_c = 8'h1e; 8'hea: sub_c = 8'h87; 8'heb: sub_c = 8'he9; 8'hec: sub_c = 8'hce; 8'hed: sub_c = 8'h55; 8'hee: sub_c = 8'h28; 8'hef: sub_c = 8'hdf;
      8'hf0: sub_c = 8'h8c; 8'hf1: sub_c = 8'ha1; 8'hf2: sub_c = 8'h89; 8'hf3: sub_c = 8'h0d; 8'hf4: sub_c = 8'hbf; 8'hf5: sub_c = 8'he6; 8'hf6: sub_c = 8'h42; 8'hf7: sub_c = 8'h68;
      8'hf8: sub_c = 8'h41; 8'hf9: sub_c = 8'h99; 8'hfa: sub_c = 8'h2d; 8'hfb: sub_c = 8'h0f; 8'hfc: sub_c = 8'hb0; 8'hfd: sub_c = 8'h54; 8'hfe: sub_c = 8'hbb; 8'hff: sub_c = 8'h16;
      default: sub_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/add_round_key.sv
// One AES-128 key-expansion step per clock; rounds outside 1..10 pass key_in through.
module add_round_key
  import add_round_key_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   round,
  input  logic [127:0] key_in,
  output logic [127:0] roundkey
);

  key_words_t        kin;
  logic [WORD_W-1:0] rot_c;
  logic [WORD_W-1:0] sub_c;
  logic [WORD_W-1:0] temp_c;
  key_words_t        expanded_c;
  logic [KEY_W-1:0]  next_c;
  logic              expand_c;

  assign kin   = key_in;
  assign rot_c = {kin.w3[23:0], kin.w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .val   (rot_c[8*i +: 8]),
      .sub_c (sub_c[8*i +: 8])
    );
  end

  // Expansion step: each new word chains off the one before it.
  always_comb begin
    temp_c        = sub_c ^ {rcon(round), 24'h000000};
    expanded_c    = '0;
    expanded_c.w0 = kin.w0 ^ temp_c;
    expanded_c.w1 = expanded_c.w0 ^ kin.w1;
    expanded_c.w2 = expanded_c.w1 ^ kin.w2;
    expanded_c.w3 = expanded_c.w2 ^ kin.w3;
    expand_c      = (round != 4'd0) && (round <= 4'(MAX_ROUND));
    next_c        = expand_c ? expanded_c : key_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) roundkey <= '0;
    else        roundkey <= next_c;
  end

endmodule

// File: tb/tb_add_round_key.sv
// Directed-vector bench for add_round_key using the FIPS-197 "Thats my Kung Fu" key.
module tb_add_round_key;

  logic         clk;
  logic         rst_n;
  logic [3:0]   round;
  logic [127:0] key_in;
  logic [127:0] roundkey;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] K0  = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] K1  = 128'hE232FCF191129188B159E4E6D679A293;
  localparam logic [127:0] K2  = 128'h56082007C71AB18F76435569A03AF7FA;
  localparam logic [127:0] K3  = 128'hD2600DE7157ABC686339E901C3031EFB;
  localparam logic [127:0] K10 = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;

  add_round_key dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .round    (round),
    .key_in   (key_in),
    .roundkey (roundkey)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, sample 1ns after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [127:0] k);
    @(negedge clk);
    round  = r;
    key_in = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b1;
    round  = 4'd3;
    key_in = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    #2 rst_n = 1'b0;
    #1 check("reset_async", roundkey, 128'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step(4'd0, K0);
    check("round0", roundkey, K0);

    step(4'd1, K0);
    check("round1", roundkey, K1);
    step(4'd2, K1);
    check("round2", roundkey, K2);
    step(4'd3, K2);
    check("round3", roundkey, K3);

    // Full chain with feedback through the DUT output.
    step(4'd0, K0);
    for (int r = 1; r <= 10; r++) begin
      step(4'(r), roundkey);
      if (r == 1) check("chain_r1", roundkey, K1);
      if (r == 3) check("chain_r3", roundkey, K3);
    end
    check("chain_r10", roundkey, K10);

    step(4'd11, 128'h0123456789ABCDEFFEDCBA9876543210);
    check("round11", roundkey, 128'h0123456789ABCDEFFEDCBA9876543210);
    step(4'd15, 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF);
    check("round15", roundkey, 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF);
    step(4'd0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    check("round0_ones", roundkey, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);

    // Mid-chain reset, asserted between edges.
    step(4'd0, K0);
    step(4'd1, roundkey);
    step(4'd2, roundkey);
    #2 rst_n = 1'b0;
    #1 check("midchain_reset", roundkey, 128'h0);
    round  = 4'd3;
    key_in = K2;
    @(posedge clk);
    #1 check("reset_hold", roundkey, 128'h0);

    @(negedge clk);
    rst_n = 1'b1;
    round = 4'd3;
    key_in = K2;
    @(posedge clk);
    #1 check("post_release", roundkey, K3);

    step(4'd1, K0);
    check("post_release_r1", roundkey, K1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
